store_data_packer: RTL



---
 rtl/store_data_packer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/store_data_packer.sv
// Store-side data packer: narrows SB/SH/SW data into a 32-bit word and writes it to
// word-wide memory, using read-modify-write for sub-word stores. Optional: STORE_BYTE_ENABLE_EN.
module store_data_packer #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [1:0]  StoreSize,
    input  logic [31:0] Addr,
    input  logic [31:0] StoreData,
    output logic [31:0] MemAddr,
    output logic        MemRead,
    input  logic [31:0] MemRdata,
    input  logic        MemRdValid,
    output logic        MemWrite,
    output logic [31:0] MemWData,
    output logic        Done,
    output logic        Error,
`ifdef STORE_BYTE_ENABLE_EN
    output logic [3:0]  MemByteEn,
`endif
    output logic        ErrCause
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [2:0]       state;
    logic [1:0]       size_q;
    logic [1:0]       lane_q;
    logic [15:0]      data_q;
    logic [CNT_W-1:0] cnt;
    logic             cause_q;
    logic [31:0]      mem_addr_q;
    logic [31:0]      mem_wdata_q;
    logic [31:0]      merged;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout_hit;
    logic             bad_req;
`ifdef STORE_BYTE_ENABLE_EN
    logic [3:0]       be_q;
`endif

    always_comb begin
        bad_req = 1'b0;
        case (StoreSize)
            SZ_HALF: bad_req = Addr[0];
            SZ_WORD: bad_req = |Addr[1:0];
            SZ_BYTE: bad_req = 1'b0;
            default: bad_req = 1'b1;
        endcase
    end

    // Little-endian lane merge of the latched store data into the fetched word.
    always_comb begin
        merged = MemRdata;
        if (size_q == SZ_BYTE) begin
            merged[{lane_q, 3'b000} +: 8] = data_q[7:0];
        end else if (lane_q[1]) begin
            merged[31:16] = data_q;
        end else begin
            merged[15:0] = data_q;
        end
    end

    assign cnt_inc     = cnt + CNT_W'(1);
    assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state       <= S_IDLE;
            size_q      <= '0;
            lane_q      <= '0;
            data_q      <= '0;
            cnt         <= '0;
            cause_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef STORE_BYTE_ENABLE_EN
            be_q        <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (ReqValid) begin
                        mem_addr_q <= {Addr[31:2], 2'b00};
                        size_q     <= StoreSize;
                        lane_q     <= Addr[1:0];
                        data_q     <= StoreData[15:0];
                        if (bad_req) begin
                            cause_q <= 1'b0;
                            state   <= S_ERR;
                        end else if (StoreSize == SZ_WORD) begin
                            mem_wdata_q <= StoreData;
`ifdef STORE_BYTE_ENABLE_EN
                            be_q        <= 4'b1111;
`endif
                            state       <= S_WRITE;
                        end else begin
`ifdef STORE_BYTE_ENABLE_EN
                            // Byte enables let the write go straight out with lanes replicated.
                            if (StoreSize == SZ_BYTE) begin
                                mem_wdata_q <= {4{StoreData[7:0]}};
                                be_q        <= 4'b0001 << Addr[1:0];
                            end else begin
                                mem_wdata_q <= {2{StoreData[15:0]}};
                                be_q        <= Addr[1] ? 4'b1100 : 4'b0011;
                            end
                            state <= S_WRITE;
`else
                            cnt   <= '0;
                            state <= S_READ;
`endif
                        end
                    end
                end
                S_READ: begin
                    if (MemRdValid) begin
                        mem_wdata_q <= merged;
                        state       <= S_WRITE;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt_inc;
                    // Read data arriving on the timeout cycle still completes the store.
                    if (MemRdValid) begin
                        mem_wdata_q <= merged;
                        state       <= S_WRITE;
                    end else if (timeout_hit) begin
                        cause_q <= 1'b1;
                        state   <= S_ERR;
                    end
                end
                S_WRITE: state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ReqReady = (state == S_IDLE) && !Reset;
    assign MemRead  = (state == S_READ);
    assign MemWrite = (state == S_WRITE);
    assign Done     = (state == S_DONE);
    assign Error    = (state == S_ERR);
    assign ErrCause = (state == S_ERR) && cause_q;
    assign MemAddr  = mem_addr_q;
    assign MemWData = mem_wdata_q;
`ifdef STORE_BYTE_ENABLE_EN
    assign MemByteEn = (state == S_WRITE) ? be_q : 4'b0000;
`endif

endmodule
